// File: rtl/mem_port_if.sv
// Request/response handshake bundle for the byte-addressable data memory port.
// master = load/store unit side, slave = memory side.
interface mem_port_if #(
    parameter int ADDR_WIDTH       = 12,
    parameter int DATA_WIDTH_BYTES = 4
);
    logic                          req_valid;
    logic                          req_ready;
    logic [ADDR_WIDTH-1:0]         req_addr;
    logic [DATA_WIDTH_BYTES-1:0]   req_wenableL;
    logic [8*DATA_WIDTH_BYTES-1:0] req_wdata;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [8*DATA_WIDTH_BYTES-1:0] resp_rdata;
    logic                          resp_err;
    logic                          resp_split;

    modport master (
        output req_valid, req_addr, req_wenableL, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_split
    );

    modport slave (
        input  req_valid, req_addr, req_wenableL, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_split
    );
endinterface

// File: rtl/mem_port.sv
// Byte-addressable word memory with valid/ready request and response handshake.
// Misaligned accesses take two word cycles (LO word, then HI word); out-of-range accesses report resp_err.
module mem_port #(
    parameter int ADDR_WIDTH       = 12,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int DEPTH_BYTES      = 4096
) (
    input  logic      clk,
    input  logic      rstL,
    mem_port_if.slave bus
);
    localparam int DWB   = DATA_WIDTH_BYTES;
    localparam int DW    = 8 * DWB;
    localparam int OFF_W = $clog2(DWB);
    localparam int WORDS = DEPTH_BYTES / DWB;
    localparam int WI_W  = $clog2(WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DW-1:0]    mem_q [WORDS];

    logic [1:0]       state_q, state_d;
    logic [WI_W-1:0]  word_q, word_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [DWB-1:0]   wen_q, wen_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             split_q, split_d;

    logic             accept;
    logic             req_err;
    logic [ADDR_WIDTH:0] req_end;

    logic             acc_en;
    logic             acc_hi;
    logic [WI_W-1:0]  acc_word;
    logic [OFF_W-1:0] acc_off;
    logic [DWB-1:0]   acc_wenL;
    logic [DW-1:0]    acc_wdata;
    logic [DW-1:0]    acc_rword;
    logic [DW-1:0]    acc_rlanes;
    logic [DWB-1:0]   lane_act;
    logic [OFF_W-1:0] lane_pos [DWB];

    assign accept  = bus.req_valid && (state_q == S_IDLE);
    assign req_end = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(DWB);
    assign req_err = req_end > (ADDR_WIDTH+1)'(DEPTH_BYTES);

    // One word access per cycle: the new request's LO word in IDLE, the following word in HI.
    always_comb begin
        acc_en    = 1'b0;
        acc_hi    = 1'b0;
        acc_word  = bus.req_addr[OFF_W +: WI_W];
        acc_off   = bus.req_addr[OFF_W-1:0];
        acc_wenL  = bus.req_wenableL;
        acc_wdata = bus.req_wdata;
        if (state_q == S_HI) begin
            acc_en    = 1'b1;
            acc_hi    = 1'b1;
            acc_word  = word_q + WI_W'(1);
            acc_off   = off_q;
            acc_wenL  = wen_q;
            acc_wdata = wdata_q;
        end else if (accept && !req_err) begin
            acc_en = 1'b1;
        end
    end

    // Lane i sits at byte (i+off) mod DWB of its word; lanes that wrap past the word end belong to HI.
    always_comb begin
        acc_rword  = mem_q[acc_word];
        acc_rlanes = '0;
        for (int i = 0; i < DWB; i++) begin
            lane_pos[i] = OFF_W'(i) + acc_off;
            lane_act[i] = ((i + int'(acc_off)) >= DWB) == acc_hi;
            if (lane_act[i]) acc_rlanes[8*i +: 8] = acc_rword[8*lane_pos[i] +: 8];
        end
    end

    // Read lanes see the pre-write contents since the write lands at the same edge.
    always_ff @(posedge clk) begin
        if (acc_en) begin
            for (int i = 0; i < DWB; i++) begin
                if (lane_act[i] && !acc_wenL[i]) mem_q[acc_word][8*lane_pos[i] +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        off_d   = off_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        split_d = split_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    word_d  = bus.req_addr[OFF_W +: WI_W];
                    off_d   = bus.req_addr[OFF_W-1:0];
                    wen_d   = bus.req_wenableL;
                    wdata_d = bus.req_wdata;
                    split_d = 1'b0;
                    if (req_err) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        rdata_d = acc_rlanes;
                        state_d = (bus.req_addr[OFF_W-1:0] == '0) ? S_RESP : S_HI;
                    end
                end
            end
            S_HI: begin
                rdata_d = rdata_q | acc_rlanes;
                split_d = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            off_q   <= '0;
            wen_q   <= '1;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            off_q   <= off_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            split_q <= split_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_split = split_q;
endmodule

// File: tb/tb_mem_port.sv
// Randomised bench for mem_port: byte-array reference model plus one per-cycle compare process,
// with directed accesses pinning literal values.
module tb_mem_port;
    localparam int AW    = 12;
    localparam int DWB   = 4;
    localparam int DEPTH = 4096;

    logic clk  = 1'b0;
    logic rstL = 1'b0;
    always #5 clk = ~clk;

    mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH_BYTES(DWB)) bus ();

    mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH_BYTES(DWB), .DEPTH_BYTES(DEPTH)) dut (
        .clk  (clk),
        .rstL (rstL),
        .bus  (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] model_mem [DEPTH];
    bit         known     [DEPTH];

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] mask;
        logic        err;
        logic        split;
        int unsigned hs;
        int unsigned lat;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Compare process: every negedge, check the DUT against the model's outstanding response.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstL) begin
                expq.delete();
            end else begin
                logic ev;
                ev = (expq.size() > 0) && (cyc >= expq[0].hs + expq[0].lat);
                chk("req_ready", 32'(bus.req_ready), 32'(expq.size() == 0));
                chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
                if (bus.resp_valid && expq.size() > 0) begin
                    chk("resp_rdata", bus.resp_rdata & expq[0].mask, expq[0].rdata & expq[0].mask);
                    chk("resp_err", 32'(bus.resp_err), 32'(expq[0].err));
                    chk("resp_split", 32'(bus.resp_split), 32'(expq[0].split));
                    if (bus.resp_ready) void'(expq.pop_front());
                end
                if (bus.req_valid && bus.req_ready) begin
                    exp_t e;
                    int   a;
                    a       = int'(bus.req_addr);
                    e.err   = (a + DWB > DEPTH);
                    e.split = !e.err && (a % DWB != 0);
                    e.lat   = e.split ? 2 : 1;
                    e.hs    = cyc;
                    e.rdata = '0;
                    e.mask  = '1;
                    if (!e.err) begin
                        for (int i = 0; i < DWB; i++) begin
                            e.rdata[8*i +: 8] = model_mem[a+i];
                            if (!known[a+i]) e.mask[8*i +: 8] = 8'h00;
                        end
                        for (int i = 0; i < DWB; i++) begin
                            if (!bus.req_wenableL[i]) begin
                                model_mem[a+i] = bus.req_wdata[8*i +: 8];
                                known[a+i]     = 1'b1;
                            end
                        end
                    end
                    expq.push_back(e);
                end
            end
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [3:0] wl, input logic [31:0] wd,
                          input int hold, input bit junk,
                          output logic [31:0] rd, output logic er, output logic sp);
        int n;
        rd = '0;
        er = 1'b0;
        sp = 1'b0;
        @(posedge clk); #2;
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_wenableL = wl;
        bus.req_wdata    = wd;
        bus.resp_ready   = (hold == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 20);
        if (!bus.req_ready) begin
            tests++; fails++;
            $display("FAIL handshake_timeout: req_ready stayed %b, required 1", bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #2;
        if (junk && hold > 0) begin
            bus.req_addr     = AW'($urandom_range(0, DEPTH - 1));
            bus.req_wenableL = 4'b0000;
            bus.req_wdata    = $urandom;
        end else begin
            bus.req_valid = 1'b0;
        end
        n = 0;
        while (!bus.resp_valid && n < 10) begin @(negedge clk); n++; end
        if (!bus.resp_valid) begin
            tests++; fails++;
            $display("FAIL resp_timeout: resp_valid stayed %b, required 1", bus.resp_valid);
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
            return;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
        sp = bus.resp_split;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            @(posedge clk); #2;
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er, sp;
        logic [7:0]  pre24;

        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_wenableL = '1;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_split", 32'(bus.resp_split), 32'd0);
        @(posedge clk); #2;
        rstL = 1'b1;

        for (int w = 0; w < DEPTH / DWB; w++) do_req(AW'(w * DWB), 4'b0000, $urandom, 0, 1'b0, rd, er, sp);

        do_req(12'h010, 4'b0000, 32'hDDCCBBAA, 0, 1'b0, rd, er, sp);
        do_req(12'h010, 4'b1111, 32'h0, 0, 1'b0, rd, er, sp);
        chk("t1_rdata", rd, 32'hDDCCBBAA);
        chk("t1_err", 32'(er), 32'd0);
        chk("t1_split", 32'(sp), 32'd0);

        do_req(12'h010, 4'b1010, 32'h11223344, 0, 1'b0, rd, er, sp);
        chk("t2_wresp", rd, 32'hDDCCBBAA);
        do_req(12'h010, 4'b1111, 32'h0, 0, 1'b0, rd, er, sp);
        chk("t2_rdata", rd, 32'hDD22BB44);
        chk("t2_model", {model_mem[16'h13], model_mem[16'h12], model_mem[16'h11], model_mem[16'h10]}, 32'hDD22BB44);

        do_req(12'h013, 4'b0000, 32'h87654321, 0, 1'b0, rd, er, sp);
        chk("t3_split", 32'(sp), 32'd1);
        chk("t3_err", 32'(er), 32'd0);
        do_req(12'h010, 4'b1111, 32'h0, 0, 1'b0, rd, er, sp);
        chk("t3_rd010", rd, 32'h2122BB44);
        do_req(12'h014, 4'b1111, 32'h0, 0, 1'b0, rd, er, sp);
        chk("t3_rd014", 32'(rd[23:0]), 32'h00876543);
        chk("t3_model", {8'h00, model_mem[16'h16], model_mem[16'h15], model_mem[16'h14]}, 32'h00876543);

        do_req(12'hFFE, 4'b0000, 32'hA5A5A5A5, 0, 1'b0, rd, er, sp);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_rdata", rd, 32'd0);
        chk("t4_split", 32'(sp), 32'd0);
        do_req(12'hFFC, 4'b1111, 32'h0, 0, 1'b0, rd, er, sp);
        do_req(12'hFFD, 4'b1111, 32'h0, 0, 1'b0, rd, er, sp);
        chk("t4_rd_ffd_err", 32'(er), 32'd1);

        do_req(12'h010, 4'b1111, 32'h0, 5, 1'b1, rd, er, sp);
        chk("t5_rdata", rd, 32'h2122BB44);

        pre24 = model_mem[16'h24];
        @(posedge clk); #2;
        bus.req_valid    = 1'b1;
        bus.req_addr     = 12'h021;
        bus.req_wenableL = 4'b0000;
        bus.req_wdata    = 32'h44332211;
        bus.resp_ready   = 1'b1;
        @(negedge clk);
        chk("t6_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
        rstL = 1'b0;
        #1;
        chk("t6_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t6_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("t6_resp_rdata", bus.resp_rdata, 32'd0);
        chk("t6_resp_split", 32'(bus.resp_split), 32'd0);
        model_mem[16'h24] = pre24;
        @(posedge clk); #2;
        rstL = 1'b1;
        do_req(12'h020, 4'b1111, 32'h0, 0, 1'b0, rd, er, sp);
        chk("t6_lo_bytes", 32'(rd[31:8]), 32'h00332211);
        do_req(12'h024, 4'b1111, 32'h0, 0, 1'b0, rd, er, sp);
        chk("t6_hi_byte", 32'(rd[7:0]), 32'(pre24));

        for (int k = 0; k < 300; k++) begin
            logic [AW-1:0] a;
            logic [3:0]    wl;
            int            hold;
            if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(DEPTH - 16, DEPTH - 1));
            else                           a = AW'($urandom_range(0, DEPTH - 1));
            wl   = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 3);
            do_req(a, wl, $urandom, hold, 1'($urandom_range(0, 1)), rd, er, sp);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
